exu_muldiv_handler: RTL and testbench

Execute-unit handler for the RV32M multiply/divide instructions: OPCODE_ALU with funct7 = 7'b0000001. It is parametrised in data width and multiplier throughput. It runs iterative multiply and divide in a small FSM, stalls the pipeline through `busy`, and writes the result back through the GPR master interface in a single write-back cycle. It sits beside the integer ALU handler under the same `sel`/`inst` dispatch.

---
 rtl/exu_muldiv_handler_pkg.sv | 40 ++++
 rtl/exu_muldiv_handler_if.sv | 19 +
 rtl/exu_muldiv_handler_div_iter.sv | 79 +++++++
 rtl/exu_muldiv_handler.sv | 216 +++++++++++++++++++++
 tb/tb_exu_muldiv_handler.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/exu_muldiv_handler_pkg.sv
// Shared ISA constants, instruction layout and FSM state names for the
// RV32M multiply/divide execute handler.
package exu_muldiv_handler_pkg;

    localparam int RV_XLEN = 32;

    localparam logic [6:0] OPCODE_ALU    = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] MD_FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] MD_FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] MD_FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] MD_FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] MD_FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] MD_FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] MD_FUNCT3_REM    = 3'b110;
    localparam logic [2:0] MD_FUNCT3_REMU   = 3'b111;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rv32i_inst_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_WB   = 2'd3
    } md_state_e;

    // funct3[2] separates the divide group from the multiply group
    function automatic logic md_is_div(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage

// File: rtl/exu_muldiv_handler_if.sv
// GPR access bundle: two read ports and one write port.
interface exu_gpr_if_t
    import exu_muldiv_handler_pkg::*;
#(
    parameter int XLEN = RV_XLEN
);
    logic [4:0]      ra1;
    logic [4:0]      ra2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            wen;
    logic [4:0]      wa;
    logic [XLEN-1:0] wd;

    modport mst (output ra1, output ra2, input rd1, input rd2,
                 output wen, output wa, output wd);
    modport slv (input ra1, input ra2, output rd1, output rd2,
                 input wen, input wa, input wd);
endinterface

// File: rtl/exu_muldiv_handler_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per
// cycle. Loads on start, steps XLEN times, raises last in the final step.
module exu_div_iter
    import exu_muldiv_handler_pkg::*;
#(
    parameter int XLEN = RV_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem,
    output logic            last
);
    localparam int CNT_W = $clog2(XLEN);

    logic             run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  quot_q, quot_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  dsr_q, dsr_d;
    logic [XLEN:0]    rem_sh;
    logic [XLEN:0]    diff;

    assign last = run_q && (cnt_q == CNT_W'(XLEN - 1));
    assign quot = quot_q;
    assign rem  = rem_q;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        run_d  = run_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dsr_d  = dsr_q;
        rem_sh = {rem_q, quot_q[XLEN-1]};
        diff   = rem_sh - {1'b0, dsr_q};
        if (start) begin
            run_d  = 1'b1;
            cnt_d  = '0;
            quot_d = dividend;
            rem_d  = '0;
            dsr_d  = divisor;
        end else if (run_q) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
                run_d = 1'b0;
            end
            if (!diff[XLEN]) begin
                rem_d  = diff[XLEN-1:0];
                quot_d = {quot_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d  = rem_sh[XLEN-1:0];
                quot_d = {quot_q[XLEN-2:0], 1'b0};
            end
        end
    end

    // Sequencing state; reset aborts any division in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        quot_q <= quot_d;
        rem_q  <= rem_d;
        dsr_q  <= dsr_d;
    end

endmodule

// File: rtl/exu_muldiv_handler.sv
// RV32M execute handler: iterative shift-add multiply and restoring divide,
// stalling through busy and writing back in a single WB cycle.
module exu_muldiv_handler
    import exu_muldiv_handler_pkg::*;
#(
    parameter int XLEN    = RV_XLEN,
    parameter int MUL_BPC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  rv32i_inst_t inst,
    exu_gpr_if_t.mst    gpr_mst,
    output logic        busy,
    output logic        done
);
    localparam int MUL_CYC = XLEN / MUL_BPC;
    localparam int CNT_W   = $clog2(MUL_CYC + 1);

    localparam logic [1:0] ST_IDLE = MD_IDLE;
    localparam logic [1:0] ST_MUL  = MD_MUL;
    localparam logic [1:0] ST_DIV  = MD_DIV;
    localparam logic [1:0] ST_WB   = MD_WB;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        rd_q, rd_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;
    logic              spec_q, spec_d;
    logic [XLEN-1:0]   spec_res_q, spec_res_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;

    logic              accept;
    logic [2:0]        f3;
    logic              is_div, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag, op_spec_res;
    logic              div_zero, div_ovf, op_special, op_neg;

    logic [XLEN+MUL_BPC-1:0] mul_pp, mul_sum;
    logic [2*XLEN-1:0]       acc_step;
    logic [2*XLEN-1:0]       prod;
    logic [XLEN-1:0]         mul_res, div_mag, div_res, wb_res;

    logic              div_start, div_last;
    logic [XLEN-1:0]   div_quot, div_rem;

    assign accept = (state_q == ST_IDLE) && sel && (inst.opcode == OPCODE_ALU)
                    && (inst.funct7 == FUNCT7_MULDIV);
    assign busy   = accept || (state_q == ST_MUL) || (state_q == ST_DIV);
    assign done   = (state_q == ST_WB);

    // Decode signedness, magnitudes and the zero-cycle divide cases
    always_comb begin
        f3         = inst.funct3;
        is_div     = md_is_div(f3);
        a_signed   = (f3 == MD_FUNCT3_MULH) || (f3 == MD_FUNCT3_MULHSU)
                     || (f3 == MD_FUNCT3_DIV) || (f3 == MD_FUNCT3_REM);
        b_signed   = (f3 == MD_FUNCT3_MULH) || (f3 == MD_FUNCT3_DIV)
                     || (f3 == MD_FUNCT3_REM);
        a_neg      = a_signed && gpr_mst.rd1[XLEN-1];
        b_neg      = b_signed && gpr_mst.rd2[XLEN-1];
        a_mag      = a_neg ? -gpr_mst.rd1 : gpr_mst.rd1;
        b_mag      = b_neg ? -gpr_mst.rd2 : gpr_mst.rd2;
        // Remainder follows the dividend sign; everything else the XOR
        op_neg     = (is_div && f3[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero   = (gpr_mst.rd2 == '0);
        div_ovf    = a_signed && (gpr_mst.rd1 == {1'b1, {(XLEN-1){1'b0}}})
                     && (gpr_mst.rd2 == '1);
        op_special = is_div && (div_zero || div_ovf);
        if (div_zero) begin
            op_spec_res = f3[1] ? gpr_mst.rd1 : '1;
        end else begin
            op_spec_res = f3[1] ? '0 : gpr_mst.rd1;
        end
    end

    // Shift-add step: add multiplicand times the low MUL_BPC multiplier bits
    always_comb begin
        mul_pp = '0;
        for (int i = 0; i < MUL_BPC; i++) begin
            if (acc_q[i]) begin
                mul_pp = mul_pp + ({{MUL_BPC{1'b0}}, mcand_q} << i);
            end
        end
        mul_sum = {{MUL_BPC{1'b0}}, acc_q[2*XLEN-1:XLEN]} + mul_pp;
    end

    if (MUL_BPC < XLEN) begin : g_acc_shift
        assign acc_step = {mul_sum, acc_q[XLEN-1:MUL_BPC]};
    end else begin : g_acc_full
        assign acc_step = mul_sum;
    end

    // Final result selection and sign restore for the write-back cycle
    always_comb begin
        prod    = neg_q ? -acc_q : acc_q;
        mul_res = (f3_q == MD_FUNCT3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        div_mag = f3_q[1] ? div_rem : div_quot;
        div_res = neg_q ? -div_mag : div_mag;
        if (spec_q) begin
            wb_res = spec_res_q;
        end else if (f3_q[2]) begin
            wb_res = div_res;
        end else begin
            wb_res = mul_res;
        end
    end

    // GPR port drive: reads in the accept cycle, write only in WB
    always_comb begin
        gpr_mst.ra1 = 'x;
        gpr_mst.ra2 = 'x;
        gpr_mst.wen = 1'b0;
        gpr_mst.wa  = 'x;
        gpr_mst.wd  = 'x;
        if (accept) begin
            gpr_mst.ra1 = inst.rs1;
            gpr_mst.ra2 = inst.rs2;
        end
        if (state_q == ST_WB) begin
            gpr_mst.wen = 1'b1;
            gpr_mst.wa  = rd_q;
            gpr_mst.wd  = wb_res;
        end
    end

    // FSM next state, operand capture and multiplier accumulation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        f3_d       = f3_q;
        neg_d      = neg_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        div_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rd_d       = inst.rd;
                    f3_d       = f3;
                    neg_d      = op_neg;
                    spec_d     = op_special;
                    spec_res_d = op_spec_res;
                    cnt_d      = '0;
                    acc_d      = {{XLEN{1'b0}}, b_mag};
                    mcand_d    = a_mag;
                    if (!is_div) begin
                        state_d = ST_MUL;
                    end else if (op_special) begin
                        state_d = ST_WB;
                    end else begin
                        state_d   = ST_DIV;
                        div_start = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                acc_d = acc_step;
                if (cnt_q == CNT_W'(MUL_CYC - 1)) begin
                    state_d = ST_WB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DIV: begin
                if (div_last) begin
                    state_d = ST_WB;
                end
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state; reset abandons any operation without write-back
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latched instruction fields and multiplier datapath
    always_ff @(posedge clk) begin
        rd_q       <= rd_d;
        f3_q       <= f3_d;
        neg_q      <= neg_d;
        spec_q     <= spec_d;
        spec_res_q <= spec_res_d;
        acc_q      <= acc_d;
        mcand_q    <= mcand_d;
    end

    exu_div_iter #(
        .XLEN (XLEN)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quot     (div_quot),
        .rem      (div_rem),
        .last     (div_last)
    );

endmodule

// File: tb/tb_exu_muldiv_handler.sv
// Scoreboard bench for exu_muldiv_handler: stimulus pushes model results,
// a monitor pops them on every write-back.
module tb_exu_muldiv_handler;
    import exu_muldiv_handler_pkg::*;

    localparam int XLEN    = 32;
    localparam int MUL_BPC = 4;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
        int          lat;
        int          issue_cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        sel;
    rv32i_inst_t inst;
    logic        busy;
    logic        done;
    logic [31:0] regs [32];
    int          cyc;
    int          n_checks;
    int          n_fail;
    int          busy_cnt;
    int          wen_seen;
    exp_t        sb_q[$];

    exu_gpr_if_t #(.XLEN(XLEN)) gpr ();

    assign gpr.rd1 = (gpr.ra1 == 5'd0) ? 32'd0 : regs[gpr.ra1];
    assign gpr.rd2 = (gpr.ra2 == 5'd0) ? 32'd0 : regs[gpr.ra2];

    exu_muldiv_handler #(.XLEN(XLEN), .MUL_BPC(MUL_BPC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel     (sel),
        .inst    (inst),
        .gpr_mst (gpr.mst),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference results straight from the RV32M definitions
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        logic   ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'(a);
        ub  = longint'(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            MD_FUNCT3_MUL:    begin p = ua * ub; return p[31:0];  end
            MD_FUNCT3_MULH:   begin p = sa * sb; return p[63:32]; end
            MD_FUNCT3_MULHSU: begin p = sa * ub; return p[63:32]; end
            MD_FUNCT3_MULHU:  begin p = ua * ub; return p[63:32]; end
            MD_FUNCT3_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            MD_FUNCT3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MD_FUNCT3_REM:    return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default:          return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
        logic sgn;
        if (!f3[2]) return XLEN / MUL_BPC + 1;
        sgn = (f3 == MD_FUNCT3_DIV) || (f3 == MD_FUNCT3_REM);
        if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Present one instruction, queue its expected result, wait for write-back
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit toggle);
        exp_t e;
        int   rs1, rs2, n;
        rs1 = $urandom_range(1, 31);
        rs2 = (rs1 % 31) + 1;
        regs[rs1] = a;
        regs[rs2] = b;
        e.wa = rd;
        e.wd = model(f3, a, b);
        e.lat = model_lat(f3, a, b);
        e.issue_cyc = cyc;
        sb_q.push_back(e);
        inst = '{funct7: FUNCT7_MULDIV, rs2: 5'(rs2), rs1: 5'(rs1), funct3: f3,
                 rd: rd, opcode: OPCODE_ALU};
        sel = 1'b1;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (toggle) begin
                inst        = rv32i_inst_t'($urandom);
                inst.opcode = OPCODE_ALU;
                inst.funct7 = FUNCT7_MULDIV;
                sel         = 1'($urandom);
            end
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wb_timeout: no write-back within %0d cycles for funct3 %0d", n, f3);
            sb_q.delete();
        end
        sel = 1'b0;
    endtask

    // Monitor: every write-back pops one expected entry
    initial begin
        exp_t e;
        busy_cnt = 0;
        wen_seen = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (gpr.wen || done) begin
                    wen_seen++;
                    cmp("done_with_wen", 32'(done), 32'(gpr.wen));
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_wb: wa=%0d wd=0x%08h, expected no write", gpr.wa, gpr.wd);
                    end else begin
                        e = sb_q.pop_front();
                        cmp("wd", gpr.wd, e.wd);
                        cmp("wa", 32'(gpr.wa), 32'(e.wa));
                        cmp("latency", 32'(cyc - e.issue_cyc), 32'(e.lat));
                        cmp("busy_cycles", 32'(busy_cnt), 32'(e.lat));
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wen_before;
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        sel      = 1'b0;
        inst     = '0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        cmp("reset_busy", 32'(busy), 32'd0);
        cmp("reset_done", 32'(done), 32'd0);
        cmp("reset_wen", 32'(gpr.wen), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(MD_FUNCT3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  1'b0);
        issue(MD_FUNCT3_MULH,   32'h8000_0000,  32'h8000_0000, 5'd6,  1'b0);
        issue(MD_FUNCT3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  1'b0);
        issue(MD_FUNCT3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  1'b0);
        issue(MD_FUNCT3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd9,  1'b0);
        issue(MD_FUNCT3_REM,    32'hFFFF_FFF9,  32'd2,         5'd10, 1'b0);
        issue(MD_FUNCT3_DIVU,   32'd5,          32'd0,         5'd11, 1'b0);
        issue(MD_FUNCT3_REM,    32'd5,          32'd0,         5'd12, 1'b0);
        issue(MD_FUNCT3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 1'b0);
        issue(MD_FUNCT3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 1'b0);

        // Reset in cycle 10 of a divide: no write-back may follow
        regs[1] = 32'd1000;
        regs[2] = 32'd7;
        inst = '{funct7: FUNCT7_MULDIV, rs2: 5'd2, rs1: 5'd1, funct3: MD_FUNCT3_DIV,
                 rd: 5'd15, opcode: OPCODE_ALU};
        sel = 1'b1;
        wen_before = wen_seen;
        repeat (10) begin @(posedge clk); #1; end
        sel   = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        cmp("midreset_busy", 32'(busy), 32'd0);
        cmp("midreset_done", 32'(done), 32'd0);
        cmp("midreset_wen", 32'(gpr.wen), 32'd0);
        rst_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; end
        cmp("midreset_no_wb", 32'(wen_seen - wen_before), 32'd0);
        issue(MD_FUNCT3_MUL, 32'd123, 32'd456, 5'd16, 1'b0);

        // Back-to-back with the instruction bus churning while busy
        issue(MD_FUNCT3_DIVU,  32'd1_000_003, 32'd17,         5'd20, 1'b1);
        issue(MD_FUNCT3_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D,  5'd21, 1'b1);

        for (int k = 0; k < 30; k++) begin
            issue(3'($urandom_range(0, 7)), pick_val(), pick_val(),
                  5'($urandom_range(0, 31)), 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
        end

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
